// File: rtl/peripheral_bin_from_bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter peripheral.
//
// Contents:
//   - register word indices (addr[4:2]) for DATA, STATUS and RESULT
//   - STATUS bit positions
//   - conversion FSM state encoding
//   - bcd_digits_valid(): checks the low 'digits' nibbles of a word for values above 9
package peripheral_bin_from_bcd_pkg;

    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_RESULT = 3'd2;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;
    localparam int ST_OVR  = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } conv_state_t;

    // Nibbles at or above 'digits' are not part of the number and are not checked.
    function automatic logic bcd_digits_valid(input logic [15:0] bcd, input int digits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < digits && bcd[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/peripheral_bin_from_bcd_core.sv
// bcd2bin_core: multi-cycle reverse double-dabble converter.
//
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   start       - request a conversion; ignored while a conversion is running
//   bcd         - packed BCD input, digit 0 in [3:0]
//   result      - binary result, valid once done is high
//   busy        - conversion in progress
//   done        - conversion (or rejection of invalid digits) finished
//   err         - last start carried a digit above 9
module bcd2bin_core
    import peripheral_bin_from_bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic [BIN_W-1:0]      result,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    conv_state_t         state;
    logic [WORK_W-1:0]   work;
    logic [WORK_W-1:0]   work_next;
    logic [CNT_W-1:0]    cnt;

    // One reverse double-dabble step: the BCD field slides right into the
    // binary field, then any digit that became 8 or more is corrected by 3
    // (a shifted-in 10 from the digit above arrives as 8 and must become 5).
    always_comb begin
        work_next = work >> 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (work_next[BIN_W + 4*i +: 4] >= 4'd8) begin
                work_next[BIN_W + 4*i +: 4] = work_next[BIN_W + 4*i +: 4] - 4'd3;
            end
        end
    end

    // Conversion FSM with registered status outputs. Starts are only taken
    // in IDLE or DONE; invalid digits skip the shifting entirely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            work   <= '0;
            cnt    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (!bcd_digits_valid(16'(bcd), DIGITS)) begin
                            err    <= 1'b1;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            result <= '0;
                            state  <= S_DONE;
                        end else begin
                            err   <= 1'b0;
                            done  <= 1'b0;
                            busy  <= 1'b1;
                            work  <= {bcd, {BIN_W{1'b0}}};
                            cnt   <= CNT_W'(BIN_W);
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    work <= work_next;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        result <= work_next[BIN_W-1:0];
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/peripheral_bin_from_bcd.sv
// peripheral_bin_from_bcd: bus wrapper around bcd2bin_core.
//
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   d_in        - write data, BCD in [4*DIGITS-1:0]
//   cs, addr    - chip select and byte address (addr[4:2] selects the register)
//   rd, wr      - read and write strobes
//   d_out       - registered read data
//
// Registers: 0x00 DATA (write starts), 0x04 STATUS {ovr,err,done,busy}, 0x08 RESULT.
module peripheral_bin_from_bcd
    import peripheral_bin_from_bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [4:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out
);

    localparam int BCD_W = 4 * DIGITS;

    logic [BCD_W-1:0] data_reg;
    logic [BCD_W-1:0] bcd_in;
    logic [BIN_W-1:0] result;
    logic             busy;
    logic             done;
    logic             err;
    logic             ovr;
    logic             start_req;
    logic [31:0]      rdata;
    logic [20:0]      unused_bus;

    assign bcd_in     = d_in[BCD_W-1:0];
    assign start_req  = cs & wr & (addr[4:2] == REG_DATA);
    // Upper data bits and byte-lane address bits carry no meaning here.
    assign unused_bus = {d_in, addr};

    bcd2bin_core #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .start  (start_req),
        .bcd    (bcd_in),
        .result (result),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    // DATA holds the last start the core actually took. A start arriving
    // mid-conversion is dropped and flagged in ovr, which stays set until
    // the next start with valid digits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_reg <= '0;
            ovr      <= 1'b0;
        end else if (start_req) begin
            if (busy) begin
                ovr <= 1'b1;
            end else begin
                data_reg <= bcd_in;
                if (bcd_digits_valid(16'(bcd_in), DIGITS)) begin
                    ovr <= 1'b0;
                end
            end
        end
    end

    // Read mux over the current (pre-edge) register values.
    always_comb begin
        rdata = '0;
        case (addr[4:2])
            REG_DATA:   rdata = 32'(data_reg);
            REG_STATUS: begin
                rdata[ST_BUSY] = busy;
                rdata[ST_DONE] = done;
                rdata[ST_ERR]  = err;
                rdata[ST_OVR]  = ovr;
            end
            REG_RESULT: rdata = 32'(result);
            default:    rdata = '0;
        endcase
    end

    // Read data is captured only on a selected read and held otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_out <= '0;
        end else if (cs && rd) begin
            d_out <= rdata;
        end
    end

endmodule

// File: tb/tb_peripheral_bin_from_bcd.sv
// Directed testbench for peripheral_bin_from_bcd (DIGITS=3, BIN_W=10).
module tb_peripheral_bin_from_bcd;

    logic        clk;
    logic        reset;
    logic [15:0] d_in;
    logic        cs;
    logic [4:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] d_out;

    int tests    = 0;
    int failures = 0;

    logic [31:0] rv;

    peripheral_bin_from_bcd #(
        .DIGITS (3),
        .BIN_W  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .d_in  (d_in),
        .cs    (cs),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .d_out (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bus cycle: inputs set at the falling edge, strobes dropped
    // 1 ns after the rising edge that consumes them.
    task automatic applyStimulus(input logic c, input logic w, input logic r,
                                 input logic [4:0] a, input logic [15:0] d);
        @(negedge clk);
        cs   = c;
        wr   = w;
        rd   = r;
        addr = a;
        d_in = d;
        @(posedge clk);
        #1;
        cs = 1'b0;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic writeReg(input logic [4:0] a, input logic [15:0] d);
        applyStimulus(1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic readReg(input logic [4:0] a, output logic [31:0] v);
        applyStimulus(1'b1, 1'b0, 1'b1, a, 16'h0);
        v = d_out;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'h00, 16'h0);
    endtask

    // Poll STATUS until done is seen; a missing done counts as a failure.
    task automatic waitDone(input string tag);
        logic [31:0] s;
        logic        seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            readReg(5'h04, s);
            if (s[1]) seen = 1'b1;
        end
        checkOutput(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        cs    = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        addr  = 5'h00;
        d_in  = 16'h0;
        #12;
        checkOutput("reset d_out", d_out, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        readReg(5'h04, rv);
        checkOutput("reset status", rv, 32'h0);

        // 999: busy visible on exactly ten polls, then done
        writeReg(5'h00, 16'h0999);
        for (int i = 0; i < 10; i++) begin
            readReg(5'h04, rv);
            checkOutput($sformatf("999 busy poll %0d", i + 1), rv, 32'h1);
        end
        readReg(5'h04, rv);
        checkOutput("999 status done", rv, 32'h2);
        readReg(5'h08, rv);
        checkOutput("999 result", rv, 32'h3E7);

        writeReg(5'h00, 16'h0000);
        waitDone("000 done");
        readReg(5'h04, rv);
        checkOutput("000 status", rv, 32'h2);
        readReg(5'h08, rv);
        checkOutput("000 result", rv, 32'h0);

        writeReg(5'h00, 16'h0255);
        waitDone("255 done");
        readReg(5'h08, rv);
        checkOutput("255 result", rv, 32'hFF);

        writeReg(5'h00, 16'h0100);
        waitDone("100 done");
        readReg(5'h08, rv);
        checkOutput("100 result", rv, 32'h64);

        // Invalid digit: err|done one edge later, result forced to 0
        writeReg(5'h00, 16'h01A3);
        readReg(5'h04, rv);
        checkOutput("invalid status", rv, 32'h6);
        readReg(5'h08, rv);
        checkOutput("invalid result", rv, 32'h0);

        // Overrun: second start at cycle 3 is dropped
        writeReg(5'h00, 16'h0123);
        idleCycle();
        idleCycle();
        writeReg(5'h00, 16'h0456);
        waitDone("ovr done");
        readReg(5'h04, rv);
        checkOutput("ovr status", rv, 32'hA);
        readReg(5'h08, rv);
        checkOutput("ovr result", rv, 32'h7B);
        readReg(5'h00, rv);
        checkOutput("ovr data kept", rv, 32'h123);
        writeReg(5'h00, 16'h0005);
        waitDone("ovr clear done");
        readReg(5'h04, rv);
        checkOutput("ovr cleared status", rv, 32'h2);
        readReg(5'h08, rv);
        checkOutput("005 result", rv, 32'h5);

        // Reset in the middle of a conversion
        writeReg(5'h00, 16'h0999);
        for (int i = 0; i < 4; i++) idleCycle();
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midreset d_out", d_out, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        readReg(5'h04, rv);
        checkOutput("midreset status", rv, 32'h0);
        readReg(5'h08, rv);
        checkOutput("midreset result", rv, 32'h0);
        readReg(5'h00, rv);
        checkOutput("midreset data", rv, 32'h0);
        writeReg(5'h00, 16'h0042);
        waitDone("042 done");
        readReg(5'h08, rv);
        checkOutput("042 result", rv, 32'h2A);

        // Same-edge read and write of DATA returns the old value
        writeReg(5'h00, 16'h0011);
        waitDone("011 done");
        applyStimulus(1'b1, 1'b1, 1'b1, 5'h00, 16'h0077);
        checkOutput("same-edge read", d_out, 32'h11);
        readReg(5'h00, rv);
        checkOutput("data after write", rv, 32'h77);
        waitDone("077 done");
        readReg(5'h08, rv);
        checkOutput("077 result", rv, 32'h4D);
        readReg(5'h0C, rv);
        checkOutput("unmapped read", rv, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/peripheral_bin_from_bcd.md
# peripheral_bin_from_bcd

Memory-mapped BCD-to-binary converter peripheral for the FemtoRV32 calculator SoC; the inverse of the existing binary-to-BCD display path. The CPU writes packed BCD digits (keypad entry), the block validates them and runs a multi-cycle reverse double-dabble (shift right, subtract 3 from any digit ≥ 8). The CPU polls status and reads the binary result. It sits on the same peripheral bus as the other calculator peripherals: chip-select, 5-bit address, rd/wr strobes.

## Interface
- DIGITS, 3: number of packed BCD digits accepted (1..4, limited by d_in width).
- BIN_W, 10: result width and iteration count; must satisfy 2^BIN_W > 10^DIGITS − 1.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- d_in  in  16  write data; [4*DIGITS-1:0] is BCD, digit 0 in [3:0].
- cs  in  1  chip select; rd/wr ignored when 0.
- addr  in  5  byte offset; addr[4:2] selects register, addr[1:0] ignored.
- rd  in  1  read strobe.
- wr  in  1  write strobe.
- d_out  out  32  registered read data.

## Operation
- Registers (word offsets):
  - 0x00 DATA: write = start, read = last accepted BCD word.
  - 0x04 STATUS: read {28'd0, ovr, err, done, busy}.
  - 0x08 RESULT: read {(32−BIN_W)'d0, result}.
  - Others read 0; writes to them are ignored.
- FSM states:
  - IDLE: after reset.
  - SHIFT: busy=1; iteration counter runs BIN_W down to 1.
  - DONE: done=1; held until next accepted start.
- Start (cs & wr & addr==0x00), accepted in IDLE or DONE:
  - Any digit > 9 → err=1, done=1, result=0; go to DONE; no shifting.
  - Otherwise → err=0, done=0, ovr=0; load {bcd, BIN_W'd0} into the working register and go to SHIFT.
- Each SHIFT cycle:
  - Shift the working register right by 1.
  - Subtract 3 from every digit ≥ 8.
  - Decrement the counter.
  - When the counter reaches 1, latch the low BIN_W bits into result and go to DONE.
- Start while in SHIFT: ignored; ovr set sticky; conversion continues.
- Reads: on a cs & rd edge, d_out loads the addressed register; otherwise d_out holds.
- Same-edge rd & wr: the read returns pre-write register values.
- Reset values: d_out=0, result=0, DATA=0, busy=done=err=ovr=0, state IDLE.

## Timing
- Write accepted at edge E0 → busy=1 after E0.
- Iterations occur at edges E1..E_BIN_W.
- After E_BIN_W: busy=0, done=1, result valid; this is 10 edges for the defaults.
- Invalid digit: done=1, err=1 one edge after the write (after E0).
- Reads have one-cycle latency: d_out shows register values sampled before the rd edge.
- Reset asserted mid-SHIFT: immediately IDLE, all outputs at reset values; the conversion is lost.
- Back-to-back starts (write in the same cycle done rises) are legal and accepted.

## Structure
- Shared package holds:
  - Register offsets: DATA=0, STATUS=1, RESULT=2 (word index).
  - STATUS bit positions: busy=0, done=1, err=2, ovr=3.
  - FSM state encoding: IDLE, SHIFT, DONE.
- Sub-module bcd2bin_core(DIGITS, BIN_W):
  - Owns the FSM, counter and working register.
  - Ports: start, bcd, result, busy, done, err.
- The wrapper owns bus decode, the DATA register, ovr and d_out.

## Test plan
- Write 0x0999 to 0x00; poll 0x04 → busy for 10 cycles, then STATUS=0x2; read 0x08 → 0x3E7.
- Write 0x0000 → RESULT=0, done=1, err=0. Write 0x0255 → RESULT=0xFF. Write 0x0100 → RESULT=0x64.
- Write 0x01A3 (digit 1 = 0xA) → one cycle later STATUS=0x6 (err|done); RESULT=0; no busy cycle.
- Write 0x0123, then write 0x0456 at cycle 3 → second write ignored; RESULT=0x7B; STATUS=0xA (ovr|done); next valid start clears ovr.
- Assert reset (low) at cycle 5 of a conversion → d_out=0, STATUS=0, RESULT=0. After release, write 0x0042 → RESULT=0x2A.
- Same-edge rd(0x00) & wr(0x00, 0x0077) after a prior 0x0011 → d_out=0x11. Next read returns 0x77. Read of offset 0x0C → 0.
